vc_scheduler: RTL and testbench
===============================

# vc_scheduler

Flow controller and configuration unit for the two-virtual-channel FIFO datapath. It programs the almost-full/almost-empty thresholds of the Main, VC and D FIFOs. It moves words from the Main FIFO into VC0/VC1 by class bit, and arbitrates VC0/VC1 into D0/D1 by destination bit with weighted priority and almost-full backpressure. It sits between the FIFO instances and drives every push/pop and the status outputs of the top level.

## Interface
- DATA_SIZE, 6, word width; bit DATA_SIZE-1 = VC class (0→VC0, 1→VC1), bit DATA_SIZE-2 = destination (0→D0, 1→D1)
- VC0_WEIGHT, 3, max consecutive VC0 grants while VC1 is eligible
- clk  in  1  single clock, all state on rising edge
- reset_L  in  1  synchronous, active-low reset
- init  in  1  request threshold (re)load
- umbral_MF_i / umbral_VC_i / umbral_DF_i  in  4/8/4  {almost_full, almost_empty} thresholds, 2/4/2 bits each
- afMF, aeMF, afVC, aeVC, afDF, aeDF  out  2,2,4,4,2,2  registered thresholds to FIFOs
- main_empty  in  1; main_data  in  DATA_SIZE (show-ahead head); main_pop  out  1
- vc_afull, vc_empty  in  2 each; vc0_data, vc1_data  in  DATA_SIZE; vc_push, vc_pop  out  2; vc_data  out  DATA_SIZE
- d_afull, d_empty  in  2 each; d_push  out  2; d_data  out  DATA_SIZE
- fifo_error  in  5  overflow/underflow flags {d1,d0,vc1,vc0,main}
- state  out  5  one-hot FSM state; idle_out, active_out, error_out  out  1

## Operation
- FIFOs are show-ahead: head valid whenever empty=0; pop/push in cycle N takes effect at edge N.
- FSM, one-hot: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
  - RESET → INIT on the first edge with reset_L=1.
  - INIT: thresholds load from umbral_* every cycle; → IDLE when init=0.
  - IDLE: → INIT if init=1. Else → ACTIVE if any of main_empty, vc_empty, d_empty is 0.
  - ACTIVE: → IDLE when all empty flags are 1. init is ignored.
  - Any state except RESET → ERROR when fifo_error≠0 (highest priority). ERROR is sticky until reset.
- Thresholds hold their value outside INIT.
- idle_out/active_out/error_out = state is IDLE/ACTIVE/ERROR (decoded from the state register).
- All push/pop outputs are 0 unless state=ACTIVE.
- Stage 1 (Main→VC): c = main_data[DATA_SIZE-1].
  - move = !main_empty & !vc_afull[c].
  - main_pop = vc_push[c] = move; vc_data = main_data.
- Stage 2 (VC→D):
  - eligible_i = !vc_empty[i] & !d_afull[dest(vci_data)].
  - Both eligible: grant VC0 unless cnt==VC0_WEIGHT, in which case grant VC1.
  - Only one eligible: grant it.
  - On grant g: vc_pop[g]=1, d_push[dest]=1, d_data=vcg_data.
- Weight counter cnt (width clog2(VC0_WEIGHT+1)):
  - +1 on a VC0 grant while VC1 is eligible, saturating.
  - Cleared on a VC1 grant.
  - Unchanged otherwise.
- Simultaneous push and pop of the same VC in one cycle is legal.

## Timing
- Reset (reset_L=0 at edge): state=RESET, all thresholds 0, cnt=0, every output 0.
- Zero-cycle transfer: push/pop are combinational from the registered state and current flags/heads.
- IDLE→ACTIVE costs one cycle: the first pop occurs the cycle after a FIFO goes non-empty.
- Sustained throughput: 1 word/cycle per stage.
- reset_L low mid-transfer: outputs are forced to 0 that same cycle.

## Test plan
- Reset then init=1 for 2 cycles with umbral_MF_i=4'b1101: state RESET→INIT→INIT→IDLE; afMF=2'b11, aeMF=2'b01 held afterwards. Umbral changes in IDLE are ignored.
- Main head 6'b0_1_0101 in IDLE: next cycle ACTIVE, main_pop=1, vc_push=2'b01, vc_data=6'h15.
- VC0 and VC1 both eligible continuously: grant order VC0,VC0,VC0,VC1,VC0,… (VC0_WEIGHT=3).
- d_afull[1]=1 with VC0 head dest=1 and VC1 head dest=0: only VC1 granted, d_push=2'b10→2'b01 (D0), no VC0 pop until d_afull clears.
- vc_afull[0]=1 with main head class 0: main_pop=0 (stall). Class-1 head behind it is not bypassed.
- fifo_error=5'b00100 while ACTIVE: next cycle state=10000, error_out=1, all push/pop 0. Stays in ERROR until reset_L=0.

Source files
------------

// File: rtl/vc_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : vc_scheduler_if
// Purpose : Bundles every FIFO-facing signal of the flow controller.
//           master = scheduler side (drives push/pop/data).
//           slave  = FIFO side (drives empty/afull flags, heads, errors).
// Signals :
//   main_empty, main_data, main_pop        Main FIFO show-ahead port
//   vc_afull, vc_empty, vc0_data, vc1_data VC FIFO status and heads
//   vc_push, vc_pop, vc_data               VC FIFO write/read strobes, write data
//   d_afull, d_empty, d_push, d_data       D FIFO status, write strobes, data
//   fifo_error                             {d1,d0,vc1,vc0,main} over/underflow
// Revision: 1.0 - initial release
// ============================================================================
interface vc_scheduler_if #(
  parameter int DATA_SIZE = 6
);
  logic                 main_empty;
  logic [DATA_SIZE-1:0] main_data;
  logic                 main_pop;

  logic [1:0]           vc_afull;
  logic [1:0]           vc_empty;
  logic [DATA_SIZE-1:0] vc0_data;
  logic [DATA_SIZE-1:0] vc1_data;
  logic [1:0]           vc_push;
  logic [1:0]           vc_pop;
  logic [DATA_SIZE-1:0] vc_data;

  logic [1:0]           d_afull;
  logic [1:0]           d_empty;
  logic [1:0]           d_push;
  logic [DATA_SIZE-1:0] d_data;

  logic [4:0]           fifo_error;

  modport master (
    input  main_empty, main_data,
    input  vc_afull, vc_empty, vc0_data, vc1_data,
    input  d_afull, d_empty,
    input  fifo_error,
    output main_pop,
    output vc_push, vc_pop, vc_data,
    output d_push, d_data
  );

  modport slave (
    output main_empty, main_data,
    output vc_afull, vc_empty, vc0_data, vc1_data,
    output d_afull, d_empty,
    output fifo_error,
    input  main_pop,
    input  vc_push, vc_pop, vc_data,
    input  d_push, d_data
  );
endinterface
`default_nettype wire

// File: rtl/vc_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : vc_scheduler
// Purpose : Flow controller / configuration unit of the two-virtual-channel
//           FIFO datapath.
//           - Registers almost-full / almost-empty thresholds of the Main, VC
//             and D FIFOs while in INIT, holds them elsewhere.
//           - Stage 1: moves the Main FIFO head into VC0/VC1 by class bit.
//           - Stage 2: arbitrates VC0/VC1 into D0/D1 by destination bit,
//             weighted in favour of VC0, honouring D almost-full.
// Ports   :
//   clk, reset_L            clock, synchronous active-low reset
//   init                    threshold (re)load request
//   umbral_MF_i/VC_i/DF_i   {almost_full, almost_empty} threshold inputs
//   afMF..aeDF              registered thresholds towards the FIFOs
//   state                   one-hot FSM state
//   idle_out/active_out/error_out  decoded state flags
//   bus                     FIFO-side handshake (vc_scheduler_if.master)
// Revision: 1.0 - initial release
// ============================================================================
module vc_scheduler #(
  parameter int DATA_SIZE  = 6,
  parameter int VC0_WEIGHT = 3
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        init,
  input  logic [3:0]  umbral_MF_i,
  input  logic [7:0]  umbral_VC_i,
  input  logic [3:0]  umbral_DF_i,
  output logic [1:0]  afMF,
  output logic [1:0]  aeMF,
  output logic [3:0]  afVC,
  output logic [3:0]  aeVC,
  output logic [1:0]  afDF,
  output logic [1:0]  aeDF,
  output logic [4:0]  state,
  output logic        idle_out,
  output logic        active_out,
  output logic        error_out,
  vc_scheduler_if.master bus
);

  // Counter must be able to hold VC0_WEIGHT itself; keep at least one bit.
  localparam int c_cnt_w = (VC0_WEIGHT > 0) ? $clog2(VC0_WEIGHT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_weight = c_cnt_w'(VC0_WEIGHT);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [1:0]          r_af_mf, r_ae_mf;
  logic [3:0]          r_af_vc, r_ae_vc;
  logic [1:0]          r_af_df, r_ae_df;
  logic [c_cnt_w-1:0]  r_cnt;

  logic                w_any_error;
  logic                w_any_nonempty;
  logic                w_all_empty;
  logic                w_en;
  logic                w_cls;
  logic                w_move;
  logic                w_dest0, w_dest1;
  logic                w_elig0, w_elig1;
  logic                w_gnt0, w_gnt1;
  logic                w_gnt_dest;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  assign w_any_error    = |bus.fifo_error;
  assign w_any_nonempty = !bus.main_empty || !(&bus.vc_empty) || !(&bus.d_empty);
  assign w_all_empty    = !w_any_nonempty;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:  w_state_next = S_INIT;
      S_INIT: begin
        if (w_any_error)   w_state_next = S_ERROR;
        else if (!init)    w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (w_any_error)         w_state_next = S_ERROR;
        else if (init)           w_state_next = S_INIT;
        else if (w_any_nonempty) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        // init is deliberately not looked at while traffic is flowing.
        if (w_any_error)      w_state_next = S_ERROR;
        else if (w_all_empty) w_state_next = S_IDLE;
      end
      S_ERROR:  w_state_next = S_ERROR;
      default:  w_state_next = S_RESET;
    endcase
  end

  assign state      = r_state;
  assign idle_out   = (r_state == S_IDLE);
  assign active_out = (r_state == S_ACTIVE);
  assign error_out  = (r_state == S_ERROR);

  // --------------------------------------------------------------------------
  // Threshold registers: reloaded every cycle spent in INIT.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_af_mf <= '0;
      r_ae_mf <= '0;
      r_af_vc <= '0;
      r_ae_vc <= '0;
      r_af_df <= '0;
      r_ae_df <= '0;
    end else if (r_state == S_INIT) begin
      r_af_mf <= umbral_MF_i[3:2];
      r_ae_mf <= umbral_MF_i[1:0];
      r_af_vc <= umbral_VC_i[7:4];
      r_ae_vc <= umbral_VC_i[3:0];
      r_af_df <= umbral_DF_i[3:2];
      r_ae_df <= umbral_DF_i[1:0];
    end
  end

  assign afMF = r_af_mf;
  assign aeMF = r_ae_mf;
  assign afVC = r_af_vc;
  assign aeVC = r_ae_vc;
  assign afDF = r_af_df;
  assign aeDF = r_ae_df;

  // --------------------------------------------------------------------------
  // Datapath control. reset_L is folded into the enable so that strobes drop
  // in the very cycle reset is asserted, before the state register reacts.
  // --------------------------------------------------------------------------
  assign w_en = reset_L && (r_state == S_ACTIVE);

  // Stage 1: Main -> VC[class]. Strictly in order: a stalled head blocks all.
  assign w_cls  = bus.main_data[DATA_SIZE-1];
  assign w_move = w_en && !bus.main_empty && !bus.vc_afull[w_cls];

  // Stage 2: VC -> D[dest] with VC0-weighted priority.
  assign w_dest0 = bus.vc0_data[DATA_SIZE-2];
  assign w_dest1 = bus.vc1_data[DATA_SIZE-2];
  assign w_elig0 = !bus.vc_empty[0] && !bus.d_afull[w_dest0];
  assign w_elig1 = !bus.vc_empty[1] && !bus.d_afull[w_dest1];

  // VC0 wins unless VC1 is also waiting and VC0 has used up its quota.
  assign w_gnt0     = w_en && w_elig0 && !(w_elig1 && (r_cnt == c_weight));
  assign w_gnt1     = w_en && w_elig1 && !w_gnt0;
  assign w_gnt_dest = w_gnt1 ? w_dest1 : w_dest0;

  assign bus.main_pop = w_move;
  assign bus.vc_push  = {w_move && w_cls, w_move && !w_cls};
  assign bus.vc_data  = w_en ? bus.main_data : '0;

  assign bus.vc_pop   = {w_gnt1, w_gnt0};
  assign bus.d_push   = (w_gnt0 || w_gnt1) ? {w_gnt_dest, !w_gnt_dest} : 2'b00;
  assign bus.d_data   = w_gnt0 ? bus.vc0_data :
                        w_gnt1 ? bus.vc1_data : '0;

  // Weight counter: counts VC0 wins that actually deprived a waiting VC1.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_cnt <= '0;
    end else if (w_gnt1) begin
      r_cnt <= '0;
    end else if (w_gnt0 && w_elig1 && (r_cnt != c_weight)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_vc_scheduler
// Purpose : Self-checking bench for vc_scheduler. Directed scenarios followed
//           by randomized traffic through queue-modelled FIFOs; every cycle
//           the DUT is compared against a rule-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vc_scheduler;

  localparam int DS = 6;
  localparam int W  = 3;

  // reference-model state indices
  localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_ERR = 4;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        init;
  logic [3:0]  umbral_MF_i;
  logic [7:0]  umbral_VC_i;
  logic [3:0]  umbral_DF_i;
  logic [1:0]  afMF, aeMF, afDF, aeDF;
  logic [3:0]  afVC, aeVC;
  logic [4:0]  state;
  logic        idle_out, active_out, error_out;

  vc_scheduler_if #(.DATA_SIZE(DS)) bus ();

  vc_scheduler #(.DATA_SIZE(DS), .VC0_WEIGHT(W)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_MF_i(umbral_MF_i), .umbral_VC_i(umbral_VC_i), .umbral_DF_i(umbral_DF_i),
    .afMF(afMF), .aeMF(aeMF), .afVC(afVC), .aeVC(aeVC), .afDF(afDF), .aeDF(aeDF),
    .state(state), .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model
  int         m_st  = M_RST;
  int         m_cnt = 0;
  logic [3:0] m_mf  = '0;
  logic [7:0] m_vc  = '0;
  logic [3:0] m_df  = '0;
  bit         e_move, e_el0, e_el1, e_en;
  int         e_g;

  // captured DUT strobes for the FIFO environment
  logic          cap_main_pop;
  logic [1:0]    cap_vc_push, cap_vc_pop, cap_d_push;
  logic [DS-1:0] cap_vc_data, cap_d_data;

  logic [DS-1:0] q_main[$], q_vc0[$], q_vc1[$], q_d0[$], q_d1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour derived from the current model state and inputs.
  task automatic calc();
    logic c;
    e_en   = reset_L && (m_st == M_ACT);
    c      = bus.main_data[DS-1];
    e_move = e_en && !bus.main_empty && !bus.vc_afull[c];
    e_el0  = !bus.vc_empty[0] && !bus.d_afull[bus.vc0_data[DS-2]];
    e_el1  = !bus.vc_empty[1] && !bus.d_afull[bus.vc1_data[DS-2]];
    e_g    = -1;
    if (e_en) begin
      if (e_el0 && e_el1) e_g = (m_cnt == W) ? 1 : 0;
      else if (e_el0)     e_g = 0;
      else if (e_el1)     e_g = 1;
    end
  endtask

  task automatic check_outputs();
    logic [1:0]    exp_push, exp_dpush;
    logic [DS-1:0] gw;
    calc();
    chk("state", state, 32'(1 << m_st));
    chk("idle_out", idle_out, 32'(m_st == M_IDLE));
    chk("active_out", active_out, 32'(m_st == M_ACT));
    chk("error_out", error_out, 32'(m_st == M_ERR));
    chk("afMF", afMF, m_mf[3:2]);
    chk("aeMF", aeMF, m_mf[1:0]);
    chk("afVC", afVC, m_vc[7:4]);
    chk("aeVC", aeVC, m_vc[3:0]);
    chk("afDF", afDF, m_df[3:2]);
    chk("aeDF", aeDF, m_df[1:0]);
    chk("main_pop", bus.main_pop, 32'(e_move));
    exp_push = 2'b00;
    if (e_move) exp_push = bus.main_data[DS-1] ? 2'b10 : 2'b01;
    chk("vc_push", bus.vc_push, exp_push);
    if (e_move) chk("vc_data", bus.vc_data, bus.main_data);
    chk("vc_pop", bus.vc_pop, (e_g < 0) ? 0 : (e_g == 0 ? 1 : 2));
    exp_dpush = 2'b00;
    if (e_g >= 0) begin
      gw = (e_g == 0) ? bus.vc0_data : bus.vc1_data;
      exp_dpush = gw[DS-2] ? 2'b10 : 2'b01;
      chk("d_data", bus.d_data, gw);
    end
    chk("d_push", bus.d_push, exp_dpush);
    if (!reset_L) begin
      chk("rst_vc_data", bus.vc_data, 0);
      chk("rst_d_data", bus.d_data, 0);
    end
  endtask

  task automatic model_edge();
    bit nonempty;
    nonempty = !bus.main_empty || (bus.vc_empty != 2'b11) || (bus.d_empty != 2'b11);
    if (!reset_L) begin
      m_st = M_RST; m_cnt = 0; m_mf = '0; m_vc = '0; m_df = '0;
    end else begin
      if (m_st == M_INIT) begin
        m_mf = umbral_MF_i; m_vc = umbral_VC_i; m_df = umbral_DF_i;
      end
      if (e_g == 1) m_cnt = 0;
      else if (e_g == 0 && e_el1 && m_cnt < W) m_cnt++;
      if (m_st == M_RST) m_st = M_INIT;
      else if (m_st != M_ERR && bus.fifo_error != 0) m_st = M_ERR;
      else if (m_st == M_INIT && !init) m_st = M_IDLE;
      else if (m_st == M_IDLE && init) m_st = M_INIT;
      else if (m_st == M_IDLE && nonempty) m_st = M_ACT;
      else if (m_st == M_ACT && !nonempty) m_st = M_IDLE;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising one.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    cap_main_pop = bus.main_pop;
    cap_vc_push  = bus.vc_push;
    cap_vc_pop   = bus.vc_pop;
    cap_d_push   = bus.d_push;
    cap_vc_data  = bus.vc_data;
    cap_d_data   = bus.d_data;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_env();
    bus.main_empty  = (q_main.size() == 0);
    bus.main_data   = (q_main.size() != 0) ? q_main[0] : DS'($urandom);
    bus.vc_empty    = {q_vc1.size() == 0, q_vc0.size() == 0};
    bus.vc0_data    = (q_vc0.size() != 0) ? q_vc0[0] : DS'($urandom);
    bus.vc1_data    = (q_vc1.size() != 0) ? q_vc1[0] : DS'($urandom);
    bus.vc_afull    = {q_vc1.size() >= 3, q_vc0.size() >= 3};
    bus.d_empty     = {q_d1.size() == 0, q_d0.size() == 0};
    bus.d_afull     = {q_d1.size() >= 3, q_d0.size() >= 3};
  endtask

  task automatic apply_env();
    if (cap_main_pop && q_main.size() != 0) void'(q_main.pop_front());
    if (cap_vc_pop[0] && q_vc0.size() != 0) void'(q_vc0.pop_front());
    if (cap_vc_pop[1] && q_vc1.size() != 0) void'(q_vc1.pop_front());
    if (cap_vc_push[0]) q_vc0.push_back(cap_vc_data);
    if (cap_vc_push[1]) q_vc1.push_back(cap_vc_data);
    if (cap_d_push[0])  q_d0.push_back(cap_d_data);
    if (cap_d_push[1])  q_d1.push_back(cap_d_data);
    if (q_d0.size() != 0 && $urandom_range(0, 2) == 0) void'(q_d0.pop_front());
    if (q_d1.size() != 0 && $urandom_range(0, 2) == 0) void'(q_d1.pop_front());
    if (q_main.size() < 4 && $urandom_range(0, 1) == 0) q_main.push_back(DS'($urandom));
  endtask

  logic [1:0] exp_order [8];

  initial begin
    reset_L = 1'b0; init = 1'b0;
    umbral_MF_i = '0; umbral_VC_i = '0; umbral_DF_i = '0;
    bus.main_empty = 1'b1; bus.main_data = '0;
    bus.vc_empty = 2'b11; bus.vc_afull = 2'b00;
    bus.vc0_data = '0; bus.vc1_data = '0;
    bus.d_empty = 2'b11; bus.d_afull = 2'b00;
    bus.fifo_error = '0;

    // ---- reset and threshold load
    @(posedge clk); #1;
    tick();
    chk("rst_state", state, 5'b00001);
    chk("rst_afVC", afVC, 0);
    reset_L = 1'b1; init = 1'b1;
    umbral_MF_i = 4'b1101; umbral_VC_i = 8'hA5; umbral_DF_i = 4'b0110;
    tick(); chk("init_first", state, 5'b00010);
    tick(); chk("init_second", state, 5'b00010);
    init = 1'b0;
    tick(); chk("to_idle", state, 5'b00100);
    chk("afMF_load", afMF, 2'b11);
    chk("aeMF_load", aeMF, 2'b01);
    chk("afVC_load", afVC, 4'hA);
    umbral_MF_i = 4'b0010; umbral_VC_i = 8'h00;
    tick();
    chk("afMF_hold", afMF, 2'b11);
    chk("aeVC_hold", aeVC, 4'h5);

    // ---- first Main word
    bus.main_empty = 1'b0; bus.main_data = 6'b010101;
    tick();
    chk("mv_state", state, 5'b01000);
    chk("mv_main_pop", bus.main_pop, 1);
    chk("mv_vc_push", bus.vc_push, 2'b01);
    chk("mv_vc_data", bus.vc_data, 6'h15);
    bus.main_empty = 1'b1;
    tick(); chk("back_idle", state, 5'b00100);

    // ---- weighted arbitration
    bus.vc_empty = 2'b00; bus.vc0_data = 6'b000000; bus.vc1_data = 6'b110000;
    tick();
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("order_%0d", i), bus.vc_pop, exp_order[i]);
      tick();
    end

    // ---- D almost-full backpressure
    bus.d_afull = 2'b10; bus.vc0_data = 6'b010000; bus.vc1_data = 6'b100000;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_vc_pop_%0d", i), bus.vc_pop, 2'b10);
      chk($sformatf("bp_d_push_%0d", i), bus.d_push, 2'b01);
      tick();
    end
    bus.d_afull = 2'b00;
    #1;
    chk("bp_release_pop", bus.vc_pop, 2'b01);
    chk("bp_release_push", bus.d_push, 2'b10);

    // ---- VC almost-full stall in stage 1
    bus.vc_empty = 2'b11; bus.vc_afull = 2'b01;
    bus.main_empty = 1'b0; bus.main_data = 6'b000111;
    #1;
    chk("stall_pop", bus.main_pop, 0);
    chk("stall_push", bus.vc_push, 2'b00);
    tick();
    chk("stall_pop_hold", bus.main_pop, 0);
    bus.vc_afull = 2'b00;
    #1;
    chk("stall_release", bus.vc_push, 2'b01);
    reset_L = 1'b0;
    #1;
    chk("rst_gate_pop", bus.main_pop, 0);
    chk("rst_gate_push", bus.vc_push, 2'b00);
    reset_L = 1'b1;
    #1;

    // ---- sticky error
    bus.fifo_error = 5'b00100;
    tick();
    chk("err_state", state, 5'b10000);
    chk("err_out", error_out, 1);
    chk("err_main_pop", bus.main_pop, 0);
    bus.fifo_error = 5'b0; bus.vc_empty = 2'b00;
    tick(); tick();
    chk("err_sticky", state, 5'b10000);
    chk("err_vc_pop", bus.vc_pop, 2'b00);
    reset_L = 1'b0;
    tick();
    chk("err_cleared", state, 5'b00001);

    // ---- randomized traffic through modelled FIFOs
    reset_L = 1'b1; init = 1'b1;
    drive_env();
    tick(); tick();
    init = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      reset_L     = ($urandom_range(0, 199) != 0);
      init        = ($urandom_range(0, 15) == 0);
      umbral_MF_i = 4'($urandom);
      umbral_VC_i = 8'($urandom);
      umbral_DF_i = 4'($urandom);
      drive_env();
      tick();
      apply_env();
    end

    // ---- random error source at the end
    reset_L = 1'b1; init = 1'b0;
    drive_env();
    tick();
    bus.fifo_error = 5'(1 << $urandom_range(0, 4));
    tick(); tick();
    chk("rand_err_state", state, 5'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
